// File: rtl/tx_byte_fifo_pkg.sv
// Shared constants and helpers for the UART byte FIFOs (TX and RX paths).
package tx_byte_fifo_pkg;

   localparam int FIFO_WIDTH      = 8;
   localparam int FIFO_DEPTH_LOG2 = 4;
   localparam int FIFO_AFULL_LVL  = 12;

   typedef logic [FIFO_WIDTH-1:0] fifo_byte_t;

   // Ceiling log2, used to size RAM addresses from a depth.
   function automatic int clogb2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/tx_byte_fifo_if.sv
// Producer/serializer-facing bus of the TX byte FIFO.
interface tx_byte_fifo_if import tx_byte_fifo_pkg::*; #(
   parameter int P_WIDTH      = FIFO_WIDTH,
   parameter int P_DEPTH_LOG2 = FIFO_DEPTH_LOG2
) ();

   logic                    wr_en;
   logic [P_WIDTH-1:0]      wr_data;
   logic                    full;
   logic                    almost_full;
   logic                    rd_en;
   logic [P_WIDTH-1:0]      rd_data;
   logic                    empty;
   logic [P_DEPTH_LOG2:0]   count;
   logic                    overflow;
   logic                    underflow;
   logic                    err_clr;

   // Producer + serializer side.
   modport master (
      output wr_en, wr_data, rd_en, err_clr,
      input  full, almost_full, rd_data, empty, count, overflow, underflow
   );

   // FIFO side.
   modport slave (
      input  wr_en, wr_data, rd_en, err_clr,
      output full, almost_full, rd_data, empty, count, overflow, underflow
   );

endinterface

// File: rtl/tx_byte_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port whose
// output holds until the next read enable.
module tx_byte_fifo_ram import tx_byte_fifo_pkg::*; #(
   parameter int P_WIDTH = FIFO_WIDTH,
   parameter int P_DEPTH = 1 << FIFO_DEPTH_LOG2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic [clogb2(P_DEPTH)-1:0]  waddr,
   input  logic [P_WIDTH-1:0]          wdata,
   input  logic                        re,
   input  logic [clogb2(P_DEPTH)-1:0]  raddr,
   output logic [P_WIDTH-1:0]          q
);

   logic [P_WIDTH-1:0] mem [P_DEPTH];

   // Write port; storage itself is never reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read; a same-address write in the same cycle returns old data.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (re) begin
         q <= mem[raddr];
      end
   end

endmodule

// File: rtl/tx_byte_fifo.sv
// TX byte FIFO in front of the RS-232 serializer: pointers, occupancy
// counter and sticky error flags around a dual-port RAM. Reads are
// registered (non-fall-through) and rd_data holds until the next pop.
module tx_byte_fifo import tx_byte_fifo_pkg::*; #(
   parameter int P_WIDTH      = FIFO_WIDTH,
   parameter int P_DEPTH_LOG2 = FIFO_DEPTH_LOG2,
   parameter int P_AFULL_LVL  = FIFO_AFULL_LVL
) (
   input logic           clk,
   input logic           rst,
   tx_byte_fifo_if.slave bus
);

   localparam int DEPTH = 1 << P_DEPTH_LOG2;
   localparam int CNT_W = P_DEPTH_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(P_AFULL_LVL);

   logic [P_DEPTH_LOG2-1:0] wp;
   logic [P_DEPTH_LOG2-1:0] rp;
   logic [CNT_W-1:0]        count_q;
   logic                    ovf_q;
   logic                    unf_q;
   logic [P_WIDTH-1:0]      rd_q;

   logic is_empty;
   logic is_full;
   logic pop_ok;
   logic push_ok;
   logic push_rej;
   logic pop_rej;
   logic ram_we;
   logic ram_re;

   // Status decodes come only from the registered count, never from pointers.
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_FULL);

   // A push into a full FIFO still succeeds when a pop frees a slot that cycle.
   assign pop_ok   = bus.rd_en && !is_empty;
   assign push_ok  = bus.wr_en && (!is_full || pop_ok);
   assign push_rej = bus.wr_en && !push_ok;
   assign pop_rej  = bus.rd_en && is_empty;

   // Requests arriving during reset are ignored.
   assign ram_we = push_ok && !rst;
   assign ram_re = pop_ok && !rst;

   tx_byte_fifo_ram #(
      .P_WIDTH (P_WIDTH),
      .P_DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .waddr (wp),
      .wdata (bus.wr_data),
      .re    (ram_re),
      .raddr (rp),
      .q     (rd_q)
   );

   // Read/write pointers, natural binary wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push_ok) begin
            wp <= wp + 1'b1;
         end
         if (pop_ok) begin
            rp <= rp + 1'b1;
         end
      end
   end

   // Occupancy: moves only when exactly one of push/pop is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (push_ok && !pop_ok) begin
         count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_q <= count_q - 1'b1;
      end
   end

   // Sticky error flags; a new error in the clear cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (push_rej) begin
            ovf_q <= 1'b1;
         end else if (bus.err_clr) begin
            ovf_q <= 1'b0;
         end
         if (pop_rej) begin
            unf_q <= 1'b1;
         end else if (bus.err_clr) begin
            unf_q <= 1'b0;
         end
      end
   end

   assign bus.rd_data     = rd_q;
   assign bus.count       = count_q;
   assign bus.empty       = is_empty;
   assign bus.full        = is_full;
   assign bus.almost_full = (count_q >= CNT_AFULL);
   assign bus.overflow    = ovf_q;
   assign bus.underflow   = unf_q;

endmodule
